mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, 32, address width in bits.
REQ-002 The block SHALL have parameter DATA_W, 32, data width in bits.
REQ-003 The block SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req0  in  1  access request from requester 0 (pipeline MEM stage).
REQ-006 The block SHALL have port we0  in  1  requester 0 write enable (1 = write, 0 = read).
REQ-007 The block SHALL have port addr0  in  ADDR_W  requester 0 address.
REQ-008 The block SHALL have port wdata0  in  DATA_W  requester 0 write data.
REQ-009 The block SHALL have ports req1, we1, addr1, wdata1 with the same directions, widths and meanings for requester 1 (loader/debug port).
REQ-010 The block SHALL have ports ack0 and ack1  out  1  one-cycle completion pulse per requester.
REQ-011 The block SHALL have port rdata  out  DATA_W  read data returned with ack.
REQ-012 The block SHALL have port stall0  out  1  pipeline hold request, equal to req0 AND NOT ack0.
REQ-013 The block SHALL have ports mem_addr (ADDR_W), mem_wdata (DATA_W), mem_read (1), mem_write (1), all out, driving the shared data memory.
REQ-014 The block SHALL have port mem_rdata  in  DATA_W  data memory read output, valid the cycle after mem_read is asserted.
REQ-015 The block SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-017 In IDLE, if any req is high, the block SHALL grant one requester, latch its we/addr/wdata into internal registers and go to ACCESS on the next edge.
REQ-018 When both req0 and req1 are high in IDLE, the block SHALL grant the port not granted last (round-robin); the pointer SHALL favour port 0 after reset.
REQ-019 When only one req is high, that port SHALL be granted regardless of the pointer.
REQ-020 In ACCESS, mem_addr and mem_wdata SHALL carry the latched values and exactly one of mem_read or mem_write SHALL be high per latched we; the block SHALL go to RESP.
REQ-021 In RESP, the granted port's ack SHALL pulse high for one cycle; for reads, rdata SHALL be loaded from mem_rdata at the end of this cycle and hold until the next read completes; the block SHALL return to IDLE.
REQ-022 mem_read and mem_write SHALL be low in IDLE and RESP; ack0 and ack1 SHALL never be high simultaneously.
REQ-023 Access latency SHALL be 3 cycles from req sampled in IDLE to ack, and back-to-back accesses SHALL issue at most one every 3 cycles.
REQ-024 A requester SHALL hold req and its operands until ack; a req deasserted after grant SHALL NOT abort the access, and ack SHALL still pulse.
REQ-025 Writes SHALL leave rdata unchanged.
REQ-026 The round-robin pointer SHALL update to the granted port when leaving IDLE.

Reset
REQ-027 On RST high, the state SHALL be IDLE, the pointer SHALL favour port 0, rdata and latched registers SHALL be 0, and ack0, ack1, mem_read, mem_write and busy SHALL be 0, immediately and independent of CLK.
REQ-028 A reset during ACCESS or RESP SHALL abandon the access with no ack; requesters SHALL re-issue after reset.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enumeration and the default ADDR_W/DATA_W constants.
REQ-030 Sub-module rr_pick2 SHALL hold the combinational two-way round-robin choice; all registers SHALL stay in mem_arbiter.

Verification
REQ-031 Reset mid-ACCESS: assert RST during ACCESS -> state IDLE, mem_write 0 immediately, no ack, memory unchanged if the write had not issued.
REQ-032 Single write then read: req0 write 0xDEADBEEF to 0x10, then read 0x10 -> ack0 on the third cycle of each access, rdata = 0xDEADBEEF.
REQ-033 Simultaneous requests after reset: req0 and req1 both held -> grants alternate 0,1,0,1, with ack0 and ack1 never overlapping.
REQ-034 Stall: req1 in progress when req0 rises -> stall0 high until ack0, which arrives at most 6 cycles later.
REQ-035 Drop request: req1 read of 0x20 deasserted during ACCESS -> ack1 still pulses and rdata = mem[0x20].

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   - default address / data widths used by mem_arbiter
//   - arbiter FSM state enumeration
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin choice (purely combinational).
// Ports:
//   req0, req1 : requests from port 0 / port 1
//   last_gnt   : port granted most recently (0 or 1)
//   gnt_vld    : at least one request is present
//   gnt_sel    : chosen port (0 or 1), meaningful when gnt_vld is high
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_vld,
    output logic gnt_sel
);

    always_comb begin
        gnt_vld = req0 | req1;
        // A lone request wins outright; a tie goes to the port not served last.
        if (req0 && req1) begin
            gnt_sel = ~last_gnt;
        end else begin
            gnt_sel = req1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one data memory between the pipeline MEM stage (port 0)
// and a loader/debug port (port 1). Each access takes IDLE -> ACCESS -> RESP.
// Ports:
//   CLK, RST                   : clock, asynchronous active-high reset
//   req/we/addr/wdata{0,1}     : per-port request, write enable and operands
//   ack0, ack1                 : one-cycle completion pulse per port
//   rdata                      : last read result, held across writes
//   stall0                     : pipeline hold, req0 and no ack0 yet
//   mem_addr/mem_wdata         : latched operands driven to the memory
//   mem_read/mem_write         : memory strobes, high only in ACCESS
//   mem_rdata                  : memory read data, valid the cycle after mem_read
//   busy                       : FSM is not in IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              stall0,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;     // port granted most recently
    logic              gnt_q, gnt_d;       // port owning the current access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;

    logic pick_vld;
    logic pick_sel;

    rr_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_q),
        .gnt_vld  (pick_vld),
        .gnt_sel  (pick_sel)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = ACCESS;
                    gnt_d   = pick_sel;
                    last_d  = pick_sel;
                    we_d    = pick_sel ? we1    : we0;
                    addr_d  = pick_sel ? addr1  : addr0;
                    wdata_d = pick_sel ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // Memory output reflects the read issued in ACCESS.
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered: decode them from the state being entered.
        mem_read_d  = (state_d == ACCESS) && !we_d;
        mem_write_d = (state_d == ACCESS) &&  we_d;
        ack0_d      = (state_d == RESP)   && !gnt_d;
        ack1_d      = (state_d == RESP)   &&  gnt_d;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;   // "port 1 served last" makes a tie favour port 0
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign stall0    = req0 & ~ack0_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, stall0, mem_read, mem_write, busy;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .stall0(stall0),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return 32'hA500_0000 | {24'd0, a};
    endfunction

    // Bench data memory: unwritten words read as a fixed pattern.
    logic [31:0] dmem [0:255];
    bit   [255:0] dmem_wr;

    function automatic logic [31:0] dmem_rd(input logic [7:0] a);
        return dmem_wr[a] ? dmem[a] : init_val(a);
    endfunction

    always @(posedge CLK) begin
        if (mem_write) begin
            dmem[mem_addr[7:0]]    <= mem_wdata;
            dmem_wr[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_read) mem_rdata <= dmem_rd(mem_addr[7:0]);
    end

    // Reference model: phase countdown (2 = memory strobe cycle, 1 = response
    // cycle, 0 = free), last-served port, and its own copy of memory contents.
    int          m_phase;
    bit          m_gnt, m_last, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] ref_arr [0:255];
    bit   [255:0] ref_wr;

    function automatic logic [31:0] ref_rd(input logic [7:0] a);
        return ref_wr[a] ? ref_arr[a] : init_val(a);
    endfunction

    wire m_pick = (req0 && req1) ? !m_last : req1;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase <= 0;
            m_last  <= 1'b1;
            m_gnt   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else begin
            case (m_phase)
                0: if (req0 || req1) begin
                    m_phase <= 2;
                    m_gnt   <= m_pick;
                    m_last  <= m_pick;
                    m_we    <= m_pick ? we1 : we0;
                    m_addr  <= m_pick ? addr1 : addr0;
                    m_wdata <= m_pick ? wdata1 : wdata0;
                end
                2: begin
                    m_phase <= 1;
                    if (m_we) begin
                        ref_arr[m_addr[7:0]] <= m_wdata;
                        ref_wr[m_addr[7:0]]  <= 1'b1;
                    end
                end
                1: begin
                    m_phase <= 0;
                    if (!m_we) m_rdata <= ref_rd(m_addr[7:0]);
                end
                default: m_phase <= 0;
            endcase
        end
    end

    wire e_ack0 = (m_phase == 1) && !m_gnt;
    wire e_ack1 = (m_phase == 1) &&  m_gnt;

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy",      32'(busy),      32'(m_phase != 0));
            chk("mem_read",  32'(mem_read),  32'((m_phase == 2) && !m_we));
            chk("mem_write", 32'(mem_write), 32'((m_phase == 2) && m_we));
            chk("ack0",      32'(ack0),      32'(e_ack0));
            chk("ack1",      32'(ack1),      32'(e_ack1));
            chk("stall0",    32'(stall0),    32'(req0 && !e_ack0));
            chk("rdata",     rdata,          m_rdata);
            if (m_phase == 2) chk("mem_addr", mem_addr, m_addr);
            if (m_phase == 2 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic drive(input bit port, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Issue one access and return the cycle number of its ack, counting the
    // cycle in which the request is first sampled as cycle 1 (0 = no ack).
    task automatic access(input bit port, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output int cyc);
        drive(port, 1'b1, w, a, d);
        cyc = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge CLK); #1;
            if (port ? ack1 : ack0) begin
                cyc = n + 1;
                break;
            end
        end
        chk("ack_seen", 32'(cyc != 0), 32'd1);
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seq[$];
        int tms[$];

        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_ack0",   32'(ack0),      32'd0);
        chk("rst_ack1",   32'(ack1),      32'd0);
        chk("rst_mread",  32'(mem_read),  32'd0);
        chk("rst_mwrite", 32'(mem_write), 32'd0);
        chk("rst_rdata",  rdata,          32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Write then read back through port 0
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, cyc);
        chk("wr_latency", 32'(cyc), 32'd3);
        @(posedge CLK); #1;
        chk("rdata_after_wr", rdata, 32'd0);
        access(1'b0, 1'b0, 32'h10, 32'd0, cyc);
        chk("rd_latency", 32'(cyc), 32'd3);
        @(posedge CLK); #1;
        chk("rd_deadbeef", rdata, 32'hDEADBEEF);

        // Port 1 read dropped during ACCESS still completes
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        @(posedge CLK); #1;
        chk("drop_busy", 32'(busy), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'hFF, 32'd0);
        @(posedge CLK); #1;
        chk("drop_ack1", 32'(ack1), 32'd1);
        @(posedge CLK); #1;
        chk("drop_rdata", rdata, 32'hA500_0020);

        // Port 0 arrives while a port 1 write is in progress
        drive(1'b1, 1'b1, 1'b1, 32'h30, 32'h12345678);
        @(posedge CLK); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'd0);
        #1;
        chk("stall_rise", 32'(stall0), 32'd1);
        cyc = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge CLK); #1;
            if (ack1) drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            if (ack0) begin
                cyc = n;
                break;
            end
            chk("stall_hold", 32'(stall0), 32'd1);
        end
        chk("stall_cycles", 32'(cyc), 32'd4);
        chk("stall_bound", 32'(cyc >= 1 && cyc <= 6), 32'd1);
        chk("stall_release", 32'(stall0), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge CLK); #1;
        chk("stall_rdata", rdata, 32'h12345678);

        // Reset while a write is in ACCESS
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
        @(posedge CLK); #1;
        chk("rma_mwrite_pre", 32'(mem_write), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("rma_mwrite", 32'(mem_write), 32'd0);
        chk("rma_busy",   32'(busy),      32'd0);
        chk("rma_ack0",   32'(ack0),      32'd0);
        chk("rma_rdata",  rdata,          32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge CLK); #1;
            chk("rma_no_ack", 32'(ack0 | ack1), 32'd0);
        end
        chk("rma_mem", dmem_rd(8'h40), 32'hA500_0040);

        // Both ports held after reset: grants alternate starting with port 0
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        for (int n = 1; n <= 20 && seq.size() < 4; n++) begin
            @(posedge CLK); #1;
            chk("rr_overlap", 32'(ack0 & ack1), 32'd0);
            if (ack0) begin seq.push_back(0); tms.push_back(n); end
            if (ack1) begin seq.push_back(1); tms.push_back(n); end
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rr_count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), (i < seq.size()) ? 32'(seq[i]) : 32'd99, 32'(i % 2));
        end
        for (int i = 1; i < tms.size(); i++) begin
            chk($sformatf("rr_gap%0d", i), 32'(tms[i] - tms[i-1]), 32'd3);
        end
        chk("rr_first", (tms.size() > 0) ? 32'(tms[0]) : 32'd0, 32'd2);

        repeat (3) @(posedge CLK);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
